// File: rtl/code_nco_pkg.sv
// Shared definitions for the GPS code NCO slice.
// Provides default widths/epoch length and the per-cycle operation type
// used by the accumulator control in code_nco.
package gps_nco_pkg;

    localparam int unsigned ACC_W_DEF           = 32;
    localparam int unsigned CHIP_W_DEF          = 10;
    localparam int unsigned CHIPS_PER_EPOCH_DEF = 1023;
    localparam int unsigned EPOCH_W             = 16;

    // What the accumulator does on a given cycle (reset handled separately).
    typedef enum logic [1:0] {
        OP_HOLD    = 2'd0,
        OP_LOAD    = 2'd1,
        OP_ADVANCE = 2'd2
    } nco_op_e;

endpackage

// File: rtl/code_nco_if.sv
// Control/status bundle for code_nco.
// master: drives en, wr_fcw/fcw_in, wr_phase/phase_in/chip_init and observes
//         plusSignal, overSignal, chip_idx, epoch_cnt, phase_out.
// slave:  the NCO itself (opposite directions).
interface code_nco_if
    import gps_nco_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CHIP_W = CHIP_W_DEF
) ();

    logic               en;
    logic               wr_fcw;
    logic [ACC_W-1:0]   fcw_in;
    logic               wr_phase;
    logic [ACC_W-1:0]   phase_in;
    logic [CHIP_W-1:0]  chip_init;
    logic               plusSignal;
    logic               overSignal;
    logic [CHIP_W-1:0]  chip_idx;
    logic [EPOCH_W-1:0] epoch_cnt;
    logic [ACC_W-1:0]   phase_out;

    modport master (
        output en, wr_fcw, fcw_in, wr_phase, phase_in, chip_init,
        input  plusSignal, overSignal, chip_idx, epoch_cnt, phase_out
    );

    modport slave (
        input  en, wr_fcw, fcw_in, wr_phase, phase_in, chip_init,
        output plusSignal, overSignal, chip_idx, epoch_cnt, phase_out
    );

endinterface

// File: rtl/chip_epoch_counter.sv
// Chip index / epoch counter driven by accumulator carry ticks.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - load chip index from load_val (out-of-range values load 0)
//   load_val    - chip index load value
//   tick        - accumulator carry this cycle (advance chip index)
//   chip_idx    - current chip index, 0..CHIPS_PER_EPOCH-1
//   epoch_cnt   - completed epochs, modulo 2^16
//   over        - registered pulse: the last tick wrapped chip_idx to 0
module chip_epoch_counter
    import gps_nco_pkg::*;
#(
    parameter int unsigned CHIP_W          = CHIP_W_DEF,
    parameter int unsigned CHIPS_PER_EPOCH = CHIPS_PER_EPOCH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [CHIP_W-1:0]  load_val,
    input  logic               tick,
    output logic [CHIP_W-1:0]  chip_idx,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               over
);

    localparam logic [CHIP_W-1:0] LAST_CHIP = CHIP_W'(CHIPS_PER_EPOCH - 1);

    logic wrap;

    assign wrap = tick && (chip_idx == LAST_CHIP);

    always_ff @(posedge clk) begin
        if (reset) begin
            chip_idx  <= '0;
            epoch_cnt <= '0;
            over      <= 1'b0;
        end else if (load) begin
            chip_idx <= (load_val > LAST_CHIP) ? '0 : load_val;
            over     <= 1'b0;
        end else if (tick) begin
            chip_idx <= wrap ? '0 : chip_idx + CHIP_W'(1);
            over     <= wrap;
            if (wrap) begin
                epoch_cnt <= epoch_cnt + EPOCH_W'(1);
            end
        end else begin
            over <= 1'b0;
        end
    end

endmodule

// File: rtl/code_nco.sv
// Code NCO: phase accumulator producing one chip tick per carry-out, with
// chip index and epoch tracking in chip_epoch_counter.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - code_nco_if slave: en, wr_fcw/fcw_in, wr_phase/phase_in/
//                chip_init in; plusSignal, overSignal, chip_idx, epoch_cnt,
//                phase_out out (all registered)
module code_nco
    import gps_nco_pkg::*;
#(
    parameter int unsigned ACC_W           = ACC_W_DEF,
    parameter int unsigned CHIP_W          = CHIP_W_DEF,
    parameter int unsigned CHIPS_PER_EPOCH = CHIPS_PER_EPOCH_DEF
) (
    input logic      clk,
    input logic      reset,
    code_nco_if.slave bus
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] fcw;
    logic [ACC_W:0]   sum;
    logic             tick;
    logic             load;
    logic             plus_q;
    nco_op_e          op;

    // Phase load wins over accumulation; the add always uses the fcw
    // currently held, so a same-cycle fcw write only affects later cycles.
    always_comb begin
        sum  = {1'b0, acc} + {1'b0, fcw};
        op   = OP_HOLD;
        if (bus.wr_phase) begin
            op = OP_LOAD;
        end else if (bus.en) begin
            op = OP_ADVANCE;
        end
        load = (op == OP_LOAD);
        tick = (op == OP_ADVANCE) && sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            fcw    <= '0;
            plus_q <= 1'b0;
        end else begin
            if (bus.wr_fcw) begin
                fcw <= bus.fcw_in;
            end
            plus_q <= tick;
            case (op)
                OP_LOAD:    acc <= bus.phase_in;
                OP_ADVANCE: acc <= sum[ACC_W-1:0];
                default:    acc <= acc;
            endcase
        end
    end

    assign bus.plusSignal = plus_q;
    assign bus.phase_out  = acc;

    chip_epoch_counter #(
        .CHIP_W          (CHIP_W),
        .CHIPS_PER_EPOCH (CHIPS_PER_EPOCH)
    ) u_chip_epoch_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_val  (bus.chip_init),
        .tick      (tick),
        .chip_idx  (bus.chip_idx),
        .epoch_cnt (bus.epoch_cnt),
        .over      (bus.overSignal)
    );

endmodule

// File: tb/tb_code_nco.sv
// Randomized + directed bench for code_nco with a scoreboard queue.
module tb_code_nco;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned CHIP_W = 10;
    localparam int unsigned CHIPS  = 1023;
    localparam longint unsigned ACC_MOD = 64'h1_0000_0000;

    typedef struct {
        bit              plus;
        bit              over;
        int unsigned     chip;
        int unsigned     epoch;
        longint unsigned acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    code_nco_if #(.ACC_W(ACC_W), .CHIP_W(CHIP_W)) bus ();

    code_nco #(
        .ACC_W           (ACC_W),
        .CHIP_W          (CHIP_W),
        .CHIPS_PER_EPOCH (CHIPS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state
    longint unsigned m_acc   = 0;
    longint unsigned m_fcw   = 0;
    int unsigned     m_chip  = 0;
    int unsigned     m_epoch = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endfunction

    // One clock of stimulus; reference model computes the state after the edge.
    task automatic step(input bit r, input bit en, input bit wf, input logic [31:0] fi,
                        input bit wp, input logic [31:0] pi, input logic [9:0] ci);
        exp_t e;
        longint unsigned s;
        @(negedge clk);
        reset        = r;
        bus.en       = en;
        bus.wr_fcw   = wf;
        bus.fcw_in   = fi;
        bus.wr_phase = wp;
        bus.phase_in = pi;
        bus.chip_init = ci;
        e.plus = 0;
        e.over = 0;
        if (r) begin
            m_acc = 0; m_fcw = 0; m_chip = 0; m_epoch = 0;
        end else begin
            if (wp) begin
                m_acc  = longint'(pi);
                m_chip = (int'(ci) >= CHIPS) ? 0 : int'(ci);
            end else if (en) begin
                s = m_acc + m_fcw;
                if (s >= ACC_MOD) begin
                    e.plus = 1;
                    m_chip = m_chip + 1;
                    if (m_chip == CHIPS) begin
                        m_chip  = 0;
                        e.over  = 1;
                        m_epoch = (m_epoch + 1) % 65536;
                    end
                end
                m_acc = s % ACC_MOD;
            end
            if (wf) m_fcw = longint'(fi);
        end
        e.chip  = m_chip;
        e.epoch = m_epoch;
        e.acc   = m_acc;
        q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a new registered output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("plusSignal", 64'(bus.plusSignal), 64'(e.plus));
                chk("overSignal", 64'(bus.overSignal), 64'(e.over));
                chk("chip_idx",   64'(bus.chip_idx),   64'(e.chip));
                chk("epoch_cnt",  64'(bus.epoch_cnt),  64'(e.epoch));
                chk("phase_out",  64'(bus.phase_out),  e.acc);
            end
        end
    end

    initial begin
        logic [31:0] f;
        reset = 1'b1;
        bus.en = 0; bus.wr_fcw = 0; bus.fcw_in = 0;
        bus.wr_phase = 0; bus.phase_in = 0; bus.chip_init = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h1234_5678, 1, 32'hFFFF_0000, 10'd7);

        // Half-rate ticks
        step(0, 0, 1, 32'h8000_0000, 0, 0, 0);
        run(10);
        // Freeze with en low, then resume
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);
        run(6);
        // fcw change on a carrying cycle
        while (m_acc != 64'h8000_0000) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h4000_0000, 0, 0, 0);
        run(12);

        // Near-full fcw
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        run(8);

        // Epoch wrap from a phase load, three times, plus same-cycle fcw write
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 32'h0000_0001, 1, 32'hFFFF_FFFF, 10'd1022);
            run(3);
        end
        // Out-of-range chip_init loads 0; in-range loads as-is
        step(0, 0, 0, 0, 1, 32'h0000_0010, 10'd1023);
        step(0, 0, 0, 0, 1, 32'h0000_0010, 10'd1000);
        // Reset mid-epoch overriding every write
        step(0, 1, 0, 0, 1, 32'h7000_0000, 10'd500);
        step(1, 1, 1, 32'h0000_0005, 1, 32'h0000_0123, 10'd7);
        run(6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0: f = $urandom;
                1: f = 32'h8000_0000;
                2: f = 32'hFFFF_FFFF;
                3: f = $urandom_range(0, 3);
                default: f = $urandom_range(32'h2000_0000, 32'hF000_0000);
            endcase
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 15) == 0), f,
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom,
                 ($urandom_range(0, 1) != 0) ? 10'($urandom_range(1015, 1023)) : 10'($urandom));
        end

        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
